// File: rtl/pla_toggle_monitor.sv
// Activity monitor for a PLA output bus: accumulates bit toggles and ones
// over a programmable sample window and returns them via valid/ready.
module pla_toggle_monitor #(
    parameter int OUT_W = 10,
    parameter int WIN_W = 16,
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIN_W-1:0] win_len,
    input  logic             in_valid,
    input  logic [OUT_W-1:0] pla_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_toggles,
    output logic [ACC_W-1:0] res_ones,
    output logic             res_ovf,
    output logic             busy
);

    localparam int PC_W  = $clog2(OUT_W + 1);
    localparam int SUM_W = ACC_W + 1;

    typedef enum logic [1:0] {IDLE, PRIME, COUNT, REPORT} state_t;

    state_t           state;
    logic [WIN_W-1:0] len;
    logic [WIN_W-1:0] count;
    logic [OUT_W-1:0] prev;
    logic [ACC_W-1:0] tog_acc;
    logic [ACC_W-1:0] ones_acc;
    logic             ovf;
    logic             valid_q;

    function automatic logic [PC_W-1:0] popcount(input logic [OUT_W-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < OUT_W; i++) begin
            n = n + PC_W'(v[i]);
        end
        return n;
    endfunction

    logic [PC_W-1:0]  pc_cur;
    logic [PC_W-1:0]  pc_tog;
    logic [SUM_W-1:0] tog_sum;
    logic [SUM_W-1:0] ones_sum;
    logic             tog_sat;
    logic             ones_sat;
    logic [ACC_W-1:0] tog_next;
    logic [ACC_W-1:0] ones_next;
    logic             last_cnt;

    assign pc_cur    = popcount(pla_out);
    assign pc_tog    = popcount(prev ^ pla_out);
    assign tog_sum   = {1'b0, tog_acc} + SUM_W'(pc_tog);
    assign ones_sum  = {1'b0, ones_acc} + SUM_W'(pc_cur);
    // The carry-out bit flags a sum past the accumulator range.
    assign tog_sat   = tog_sum[ACC_W];
    assign ones_sat  = ones_sum[ACC_W];
    assign tog_next  = tog_sat ? '1 : tog_sum[ACC_W-1:0];
    assign ones_next = ones_sat ? '1 : ones_sum[ACC_W-1:0];
    assign last_cnt  = (count + WIN_W'(1)) == len;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            len      <= '0;
            count    <= '0;
            prev     <= '0;
            tog_acc  <= '0;
            ones_acc <= '0;
            ovf      <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        len      <= win_len;
                        count    <= '0;
                        tog_acc  <= '0;
                        ones_acc <= '0;
                        ovf      <= 1'b0;
                        state    <= (win_len == '0) ? REPORT : PRIME;
                    end
                end
                PRIME: begin
                    if (in_valid) begin
                        prev     <= pla_out;
                        ones_acc <= ones_next;
                        ovf      <= ovf | ones_sat;
                        count    <= WIN_W'(1);
                        if (len == WIN_W'(1)) begin
                            state   <= REPORT;
                            valid_q <= 1'b1;
                        end else begin
                            state <= COUNT;
                        end
                    end
                end
                COUNT: begin
                    if (in_valid) begin
                        prev     <= pla_out;
                        tog_acc  <= tog_next;
                        ones_acc <= ones_next;
                        ovf      <= ovf | tog_sat | ones_sat;
                        count    <= count + WIN_W'(1);
                        if (last_cnt) begin
                            state   <= REPORT;
                            valid_q <= 1'b1;
                        end
                    end
                end
                REPORT: begin
                    // A zero-length window enters here without a result yet.
                    if (!valid_q) begin
                        valid_q <= 1'b1;
                    end else if (res_ready) begin
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign res_valid   = valid_q;
    assign res_toggles = tog_acc;
    assign res_ones    = ones_acc;
    assign res_ovf     = ovf;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_pla_toggle_monitor.sv
// Directed bench for pla_toggle_monitor: a default-width instance plus a
// 4-bit-accumulator instance sharing the same stimulus.
module tb_pla_toggle_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] win_len;
    logic        in_valid;
    logic [9:0]  pla_out;
    logic        res_ready;

    logic        res_valid;
    logic [23:0] res_toggles;
    logic [23:0] res_ones;
    logic        res_ovf;
    logic        busy;

    logic        s_valid;
    logic [3:0]  s_toggles;
    logic [3:0]  s_ones;
    logic        s_ovf;
    logic        s_busy;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pla_toggle_monitor dut (
        .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len),
        .in_valid(in_valid), .pla_out(pla_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_toggles(res_toggles), .res_ones(res_ones),
        .res_ovf(res_ovf), .busy(busy)
    );

    pla_toggle_monitor #(.ACC_W(4)) sat (
        .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len),
        .in_valid(in_valid), .pla_out(pla_out),
        .res_valid(s_valid), .res_ready(res_ready),
        .res_toggles(s_toggles), .res_ones(s_ones),
        .res_ovf(s_ovf), .busy(s_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [9:0] v);
        in_valid = 1'b1;
        pla_out  = v;
        tick();
        in_valid = 1'b0;
        pla_out  = '0;
    endtask

    task automatic go(input logic [15:0] n);
        start   = 1'b1;
        win_len = n;
        tick();
        start   = 1'b0;
        win_len = '0;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        win_len   = '0;
        in_valid  = 1'b0;
        pla_out   = '0;
        res_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;

        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tog", 32'(res_toggles), 32'd0);
        chk("rst_ones", 32'(res_ones), 32'd0);
        chk("rst_ovf", 32'(res_ovf), 32'd0);

        // Basic 4-sample window
        go(16'd4);
        chk("t1_busy", 32'(busy), 32'd1);
        send(10'h000);
        send(10'h3FF);
        send(10'h3FF);
        chk("t1_not_yet", 32'(res_valid), 32'd0);
        send(10'h001);
        chk("t1_valid", 32'(res_valid), 32'd1);
        chk("t1_tog", 32'(res_toggles), 32'd19);
        chk("t1_ones", 32'(res_ones), 32'd21);
        chk("t1_ovf", 32'(res_ovf), 32'd0);
        tick();
        chk("t1_drop", 32'(res_valid), 32'd0);
        chk("t1_idle", 32'(busy), 32'd0);

        // Single sample
        go(16'd1);
        send(10'h155);
        chk("t2_valid", 32'(res_valid), 32'd1);
        chk("t2_tog", 32'(res_toggles), 32'd0);
        chk("t2_ones", 32'(res_ones), 32'd5);
        tick();
        chk("t2_idle", 32'(busy), 32'd0);

        // Zero window, samples offered must be ignored
        start    = 1'b1;
        win_len  = 16'd0;
        in_valid = 1'b1;
        pla_out  = 10'h3FF;
        tick();
        start = 1'b0;
        chk("t2z_c1_valid", 32'(res_valid), 32'd0);
        chk("t2z_c1_busy", 32'(busy), 32'd1);
        tick();
        chk("t2z_c2_valid", 32'(res_valid), 32'd1);
        chk("t2z_tog", 32'(res_toggles), 32'd0);
        chk("t2z_ones", 32'(res_ones), 32'd0);
        in_valid = 1'b0;
        pla_out  = '0;
        tick();
        chk("t2z_drop", 32'(res_valid), 32'd0);
        chk("t2z_idle", 32'(busy), 32'd0);

        // Gaps and backpressure
        res_ready = 1'b0;
        go(16'd3);
        send(10'h001);
        tick(); tick(); tick();
        chk("t3_gap_busy", 32'(busy), 32'd1);
        send(10'h002);
        tick(); tick(); tick();
        chk("t3_gap_valid", 32'(res_valid), 32'd0);
        send(10'h004);
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", 32'(res_valid), 32'd1);
            chk("t3_hold_tog", 32'(res_toggles), 32'd4);
            chk("t3_hold_ones", 32'(res_ones), 32'd3);
            start    = 1'b1;
            win_len  = 16'd1;
            in_valid = 1'b1;
            pla_out  = 10'h3FF;
            tick();
        end
        chk("t3_hold_end", 32'(res_valid), 32'd1);
        chk("t3_hold_tog_end", 32'(res_toggles), 32'd4);
        res_ready = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        pla_out  = '0;
        chk("t3_drop", 32'(res_valid), 32'd0);
        chk("t3_idle", 32'(busy), 32'd0);
        tick();
        chk("t3_no_restart", 32'(busy), 32'd0);

        // Saturation on the narrow instance
        go(16'd3);
        send(10'h000);
        send(10'h3FF);
        send(10'h000);
        chk("t4_s_valid", 32'(s_valid), 32'd1);
        chk("t4_s_tog", 32'(s_toggles), 32'd15);
        chk("t4_s_ones", 32'(s_ones), 32'd10);
        chk("t4_s_ovf", 32'(s_ovf), 32'd1);
        chk("t4_w_tog", 32'(res_toggles), 32'd20);
        chk("t4_w_ovf", 32'(res_ovf), 32'd0);
        tick();
        go(16'd2);
        send(10'h001);
        send(10'h001);
        chk("t4b_s_valid", 32'(s_valid), 32'd1);
        chk("t4b_s_ovf", 32'(s_ovf), 32'd0);
        chk("t4b_s_tog", 32'(s_toggles), 32'd0);
        chk("t4b_s_ones", 32'(s_ones), 32'd2);
        tick();

        // Reset mid-window
        go(16'd8);
        send(10'h3FF);
        send(10'h000);
        send(10'h3FF);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_valid", 32'(res_valid), 32'd0);
        chk("t5_tog", 32'(res_toggles), 32'd0);
        chk("t5_ones", 32'(res_ones), 32'd0);
        chk("t5_ovf", 32'(res_ovf), 32'd0);
        tick();
        tick();
        chk("t5_no_result", 32'(res_valid), 32'd0);
        go(16'd2);
        send(10'h3FF);
        send(10'h000);
        chk("t5b_valid", 32'(res_valid), 32'd1);
        chk("t5b_tog", 32'(res_toggles), 32'd10);
        chk("t5b_ones", 32'(res_ones), 32'd10);
        tick();
        chk("t5b_idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
